// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake
// and holds the word for the decoder until it advances.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             pc_src,
  input  logic [15:0]      branch_off,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instruction,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0] pc_rst;
  logic [31:0] br_add;
  logic [31:0] next_pc;
  logic        take_ack;
  logic        take_adv;

  assign pc_rst = {RESET_PC[31:2], 2'b00};

  // pc stays word aligned, so the sum never touches bits [1:0]
  assign br_add  = pc_src ? {{14{branch_off[15]}}, branch_off, 2'b00}
                          : 32'd0;
  assign next_pc = pc + 32'd4 + br_add;

  assign take_ack = (state == FETCH) && imem_ack;
  assign take_adv = (state == HOLD) && advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (imem_ack) state_nxt = HOLD;
      HOLD:    if (advance)  state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      FETCH:   imem_req    = 1'b1;
      HOLD:    instr_valid = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= pc_rst;
      instruction <= 32'd0;
      retired_cnt <= '0;
    end else begin
      if (take_ack)
        instruction <= imem_rdata;
      if (take_adv) begin
        pc          <= next_pc;
        retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
